// File: rtl/synth_pkg.sv
// +----------------------------------------------------------------------------+
// | synth_pkg : shared constants and FSM state type for the wave playback path |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package synth_pkg;

  localparam int NUM_OSCILLATORS = 4;
  localparam int SAMPLE_W        = 16;
  localparam int PHASE_FRAC      = 16;
  localparam int RAM_LATENCY     = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADVANCE = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ACCUM   = 3'd3,
    ST_OUTPUT  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/osc_phase_acc.sv
// +----------------------------------------------------------------------------+
// | osc_phase_acc : 16.16 phase accumulator for one oscillator with wrap       |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module osc_phase_acc (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        i_update,
  input  logic        i_on,
  input  logic [15:0] i_width,
  input  logic [31:0] i_step,
  output logic [15:0] o_index_next
);

  import synth_pkg::*;

  localparam int PHASE_W = SAMPLE_W + PHASE_FRAC;

  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] w_phase_next;
  logic [PHASE_W:0]   w_limit;
  logic [PHASE_W:0]   w_sum;
  logic [PHASE_W:0]   w_wrap;

  // One extra bit keeps phase+step exact even when it passes 2^32.
  assign w_limit = {1'b0, i_width, {PHASE_FRAC{1'b0}}};
  assign w_sum   = {1'b0, r_phase} + {1'b0, i_step};
  assign w_wrap  = w_sum - w_limit;

  always_comb begin
    w_phase_next = '0;
    if (!i_on || (i_width == '0)) begin
      w_phase_next = '0;
    end else if (w_sum < w_limit) begin
      w_phase_next = w_sum[PHASE_W-1:0];
    end else if (w_wrap < w_limit) begin
      w_phase_next = w_wrap[PHASE_W-1:0];
    end else begin
      w_phase_next = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_phase <= '0;
    end else if (i_update) begin
      r_phase <= w_phase_next;
    end
  end

  assign o_index_next = w_phase_next[PHASE_W-1 -: SAMPLE_W];

endmodule

`default_nettype wire

// File: rtl/wave_playback.sv
// +----------------------------------------------------------------------------+
// | wave_playback : per-trigger oscillator advance, RAM wait, mix and output   |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module wave_playback #(
  parameter int NUM_OSCILLATORS = synth_pkg::NUM_OSCILLATORS,
  parameter int RAM_LATENCY     = synth_pkg::RAM_LATENCY
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          sample_trig_in,
  input  logic [15:0]                   wave_width_in,
  input  logic [NUM_OSCILLATORS-1:0]    osc_is_on_in,
  input  logic [NUM_OSCILLATORS*32-1:0] osc_step_in,
  output logic [NUM_OSCILLATORS*16-1:0] osc_index_out,
  input  logic [NUM_OSCILLATORS*16-1:0] osc_data_in,
  output logic [15:0]                   audio_out,
  output logic                          audio_valid_out,
  output logic                          busy_out,
  output logic                          overrun_out
);

  import synth_pkg::*;

  localparam int SHIFT  = $clog2(NUM_OSCILLATORS);
  localparam int SUM_W  = SAMPLE_W + SHIFT;
  localparam int WCNT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

  localparam logic [WCNT_W-1:0]      WAIT_LAST = WCNT_W'(RAM_LATENCY - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX  = SUM_W'(32767);
  localparam logic signed [SUM_W-1:0] SAT_MIN  = -SUM_W'(32768);

  state_t                          r_state;
  logic [WCNT_W-1:0]               r_wait_cnt;
  logic [NUM_OSCILLATORS-1:0]      r_on;
  logic [NUM_OSCILLATORS*16-1:0]   r_index;
  logic signed [SUM_W-1:0]         r_sum;
  logic [15:0]                     r_audio;
  logic                            r_valid;
  logic                            r_overrun;

  logic                            w_advance;
  logic [NUM_OSCILLATORS*16-1:0]   w_index_next;
  logic signed [SUM_W-1:0]         w_mix;
  logic signed [SUM_W-1:0]         w_shifted;
  logic [15:0]                     w_audio;

  assign w_advance = (r_state == ST_ADVANCE);

  for (genvar gi = 0; gi < NUM_OSCILLATORS; gi++) begin : g_osc
    osc_phase_acc u_acc (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .i_update     (w_advance),
      .i_on         (osc_is_on_in[gi]),
      .i_width      (wave_width_in),
      .i_step       (osc_step_in[gi*32 +: 32]),
      .o_index_next (w_index_next[gi*SAMPLE_W +: SAMPLE_W])
    );
  end

  // Enable mask is the one captured in ADVANCE, not the live input.
  always_comb begin
    w_mix = '0;
    for (int i = 0; i < NUM_OSCILLATORS; i++) begin
      if (r_on[i]) begin
        w_mix = w_mix + SUM_W'($signed(osc_data_in[i*SAMPLE_W +: SAMPLE_W]));
      end
    end
  end

  assign w_shifted = r_sum >>> SHIFT;

  always_comb begin
    w_audio = w_shifted[SAMPLE_W-1:0];
    if (w_shifted > SAT_MAX) begin
      w_audio = 16'h7FFF;
    end else if (w_shifted < SAT_MIN) begin
      w_audio = 16'h8000;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_on       <= '0;
      r_index    <= '0;
      r_sum      <= '0;
      r_audio    <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (sample_trig_in && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (sample_trig_in) begin
            r_state <= ST_ADVANCE;
          end
        end
        ST_ADVANCE: begin
          r_on       <= osc_is_on_in;
          r_index    <= w_index_next;
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_wait_cnt == WAIT_LAST) begin
            r_wait_cnt <= '0;
            r_state    <= ST_ACCUM;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_ACCUM: begin
          r_sum   <= w_mix;
          r_state <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          r_audio <= w_audio;
          r_valid <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign osc_index_out   = r_index;
  assign audio_out       = r_audio;
  assign audio_valid_out = r_valid;
  assign busy_out        = (r_state != ST_IDLE);
  assign overrun_out     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_wave_playback.sv
// +----------------------------------------------------------------------------+
// | tb_wave_playback : randomized self-checking bench against a phase/mix model|
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_wave_playback;

  localparam int N   = 4;
  localparam int L   = 2;
  localparam int LAT = 4 + L;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            sample_trig_in;
  logic [15:0]     wave_width_in;
  logic [N-1:0]    osc_is_on_in;
  logic [N*32-1:0] osc_step_in;
  logic [N*16-1:0] osc_index_out;
  logic [N*16-1:0] osc_data_in;
  logic [15:0]     audio_out;
  logic            audio_valid_out;
  logic            busy_out;
  logic            overrun_out;

  always #5 clk_in = ~clk_in;

  wave_playback #(
    .NUM_OSCILLATORS (N),
    .RAM_LATENCY     (L)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sample_trig_in  (sample_trig_in),
    .wave_width_in   (wave_width_in),
    .osc_is_on_in    (osc_is_on_in),
    .osc_step_in     (osc_step_in),
    .osc_index_out   (osc_index_out),
    .osc_data_in     (osc_data_in),
    .audio_out       (audio_out),
    .audio_valid_out (audio_valid_out),
    .busy_out        (busy_out),
    .overrun_out     (overrun_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference state: phases as plain integers, stimulus for the next trigger
  longint       mph [N];
  bit           exp_overrun;
  bit           const_mode;
  logic [15:0]  const_val [N];
  int unsigned  data_seed;
  logic [N-1:0] s_on;
  logic [15:0]  s_width;
  logic [31:0]  s_step [N];

  function automatic logic [15:0] ram_data(input int osc, input logic [15:0] idx);
    logic [31:0] t;
    if (const_mode) return const_val[osc];
    t = 32'(idx) * 32'd40503 + 32'(osc) * 32'd7919 + data_seed;
    return t[23:8];
  endfunction

  // Oscillator RAM with L=2 cycles of read latency
  logic [N*16-1:0] ram_s1;
  always @(posedge clk_in) begin
    for (int i = 0; i < N; i++) begin
      ram_s1[i*16 +: 16] <= ram_data(i, osc_index_out[i*16 +: 16]);
    end
    osc_data_in <= ram_s1;
  end

  function automatic void model_advance();
    for (int i = 0; i < N; i++) begin
      if (!s_on[i] || s_width == 16'd0) begin
        mph[i] = 0;
      end else begin
        longint lim = longint'(s_width) * 65536;
        longint nx  = mph[i] + longint'(s_step[i]);
        if (nx >= lim) nx = nx - lim;
        if (nx >= lim) nx = 0;
        mph[i] = nx;
      end
    end
  endfunction

  function automatic logic [15:0] model_audio();
    longint sum = 0;
    longint q;
    for (int i = 0; i < N; i++) begin
      if (s_on[i]) sum += longint'($signed(ram_data(i, 16'(mph[i] / 65536))));
    end
    q = (sum >= 0) ? sum / 4 : -((-sum + 3) / 4);
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return 16'(q);
  endfunction

  task automatic drive_inputs();
    osc_is_on_in  = s_on;
    wave_width_in = s_width;
    for (int i = 0; i < N; i++) osc_step_in[i*32 +: 32] = s_step[i];
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_index"}, osc_index_out, 0);
    check({tag, "_audio"}, audio_out, 0);
    check({tag, "_valid"}, audio_valid_out, 0);
    check({tag, "_busy"}, busy_out, 0);
    check({tag, "_overrun"}, overrun_out, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    sample_trig_in = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int i = 0; i < N; i++) mph[i] = 0;
    exp_overrun = 1'b0;
  endtask

  task automatic run_sample(input string tag);
    logic [15:0] ea;
    int cyc;
    @(negedge clk_in);
    drive_inputs();
    sample_trig_in = 1'b1;
    model_advance();
    ea = model_audio();
    @(negedge clk_in);
    sample_trig_in = 1'b0;
    cyc = 1;
    while (!audio_valid_out && cyc < 20) begin
      if (cyc >= 2) begin
        osc_is_on_in  = N'($urandom);
        wave_width_in = 16'($urandom);
        for (int i = 0; i < N; i++) osc_step_in[i*32 +: 32] = $urandom;
      end
      @(negedge clk_in);
      cyc++;
    end
    check({tag, "_latency"}, cyc, LAT);
    for (int i = 0; i < N; i++) check({tag, "_index"}, osc_index_out[i*16 +: 16], mph[i] / 65536);
    check({tag, "_audio"}, audio_out, ea);
    check({tag, "_overrun"}, overrun_out, exp_overrun);
    @(negedge clk_in);
    check({tag, "_pulse"}, audio_valid_out, 0);
  endtask

  task automatic count_pulses(input int ncyc, output int pulses);
    pulses = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk_in);
      if (audio_valid_out) pulses++;
    end
  endtask

  initial begin
    #800000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int pulses;
    rst_in = 1'b0;
    sample_trig_in = 1'b0;
    wave_width_in = '0;
    osc_is_on_in = '0;
    osc_step_in = '0;
    const_mode = 1'b0;
    data_seed = $urandom;
    for (int i = 0; i < N; i++) begin
      const_val[i] = '0;
      s_step[i] = '0;
    end
    repeat (2) @(negedge clk_in);
    apply_reset();

    // Unit step, width 512: indices 1..511 then 0
    s_on = 4'b0001;
    s_width = 16'd512;
    s_step[0] = 32'h0001_0000;
    for (int i = 1; i < N; i++) s_step[i] = $urandom;
    for (int k = 0; k < 512; k++) begin
      run_sample("ramp");
      check("ramp_seq", osc_index_out[15:0], (k + 1) % 512);
    end

    // Half step: each index twice
    apply_reset();
    s_step[0] = 32'h0000_8000;
    for (int k = 0; k < 8; k++) begin
      run_sample("half");
      check("half_seq", osc_index_out[15:0], (k + 1) / 2);
    end

    // Mixer extremes
    const_mode = 1'b1;
    for (int i = 0; i < N; i++) const_val[i] = 16'h7FFF;
    s_on = 4'b1111;
    run_sample("mixmax");
    check("mix_max", audio_out, 16'h7FFF);
    for (int i = 0; i < N; i++) const_val[i] = 16'h8000;
    s_on = 4'b0011;
    run_sample("mixneg");
    check("mix_neg", audio_out, 16'hC000);
    const_mode = 1'b0;

    // Large step wraps once; width 0 forces index 0
    apply_reset();
    s_on = 4'b0001;
    s_width = 16'd512;
    s_step[0] = 32'h0300_0000;
    run_sample("wrap");
    check("wrap_idx", osc_index_out[15:0], 16'h0100);
    s_width = 16'd0;
    run_sample("width0");
    check("width0_idx", osc_index_out[15:0], 16'h0000);

    // Trigger while busy: ignored, sticky overrun
    apply_reset();
    s_on = 4'b1111;
    s_width = 16'd300;
    for (int i = 0; i < N; i++) s_step[i] = $urandom_range(0, 300 * 65536);
    @(negedge clk_in);
    drive_inputs();
    sample_trig_in = 1'b1;
    model_advance();
    @(negedge clk_in);
    sample_trig_in = 1'b0;
    @(negedge clk_in);
    sample_trig_in = 1'b1;
    @(negedge clk_in);
    sample_trig_in = 1'b0;
    count_pulses(20, pulses);
    check("ovr_pulses", pulses, 1);
    check("ovr_index", osc_index_out[15:0], mph[0] / 65536);
    check("ovr_flag", overrun_out, 1);
    exp_overrun = 1'b1;
    for (int k = 0; k < 3; k++) run_sample("ovr_sticky");
    apply_reset();

    // Reset during WAIT aborts the sample
    s_on = 4'b1111;
    s_width = 16'd1000;
    for (int i = 0; i < N; i++) s_step[i] = $urandom_range(0, 1000 * 65536 - 1);
    @(negedge clk_in);
    drive_inputs();
    sample_trig_in = 1'b1;
    @(negedge clk_in);
    sample_trig_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int i = 0; i < N; i++) mph[i] = 0;
    exp_overrun = 1'b0;
    count_pulses(12, pulses);
    check("midrst_pulses", pulses, 0);
    run_sample("postrst");
    check("postrst_idx", osc_index_out[15:0], s_step[0] >> 16);

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      s_on = N'($urandom);
      s_width = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 1023));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) s_step[i] = $urandom;
        else s_step[i] = $urandom_range(0, 32'(s_width) << 17);
      end
      if ($urandom_range(0, 15) == 0) data_seed = $urandom;
      run_sample("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
